mac_dot_sched: RTL and testbench

Sequencer that computes one floating-point dot product of a command-specified length on a single shared, fully pipelined, non-stallable multiply-accumulate unit (z = a*b + c, fixed latency). It sits between an operand streamer and the MAC inside a GEMM processing element. It hides the MAC's accumulate-loop latency by interleaving MAC_LAT partial sums, then folds those partials into a single result using the same MAC. One command is in flight at a time; the result is returned on a valid/ready port.

---
 rtl/mac_dot_sched.sv | 207 ++++++++++++++++++++
 tb/tb_mac_dot_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sched.sv
// mac_dot_sched: dot-product sequencer that interleaves MAC_LAT partial sums on one shared pipelined MAC.
// Define MAC_DOT_SCHED_STALL_CNT_EN to add the stall_cnt output (counts input bubbles during ACCUM).
module mac_dot_sched #(
    parameter int                DATA_W  = 32,
    parameter int                MAC_LAT = 4,
    parameter int                LEN_W   = 16,
    parameter logic [DATA_W-1:0] ONE     = 32'h3F800000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic [DATA_W-1:0] mac_c,
    input  logic [DATA_W-1:0] mac_z,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
`ifdef MAC_DOT_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int SLOT_W = $clog2(MAC_LAT);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_RED_ISSUE,
        S_RED_WAIT,
        S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [LEN_W-1:0]                  len_q, len_d;
    logic [LEN_W-1:0]                  issued_q, issued_d;
    logic [SLOT_W-1:0]                 slot_q, slot_d;
    logic [SLOT_W-1:0]                 red_q, red_d;
    logic [SLOT_W-1:0]                 wait_q, wait_d;
    logic [DATA_W-1:0]                 acc_q, acc_d;
    logic [MAC_LAT-1:0][DATA_W-1:0]    psum_q, psum_d;
    logic [MAC_LAT-1:0]                tag_vld_q, tag_vld_d;
    logic [MAC_LAT-1:0][SLOT_W-1:0]    tag_slot_q, tag_slot_d;

    logic              issue;
    logic              ret_vld;
    logic [SLOT_W-1:0] ret_slot;

    assign ret_vld  = tag_vld_q[MAC_LAT-1];
    assign ret_slot = tag_slot_q[MAC_LAT-1];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        slot_d     = slot_q;
        red_d      = red_q;
        wait_d     = wait_q;
        acc_d      = acc_q;
        psum_d     = psum_q;
        issue      = 1'b0;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = (state_q != S_IDLE);
        mac_a      = '0;
        mac_b      = '0;
        mac_c      = '0;
        res_data   = acc_q;

        // Tagged MAC returns land in their slot regardless of the current state.
        if (ret_vld) begin
            psum_d[ret_slot] = mac_z;
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    len_d    = cmd_len;
                    issued_d = '0;
                    slot_d   = '0;
                    red_d    = SLOT_W'(1);
                    wait_d   = '0;
                    acc_d    = '0;
                    psum_d   = '0;
                    state_d  = (cmd_len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = (issued_q < len_q);
                if (in_valid && in_ready) begin
                    issue    = 1'b1;
                    mac_a    = in_a;
                    mac_b    = in_b;
                    mac_c    = (ret_vld && (ret_slot == slot_q)) ? mac_z : psum_q[slot_q];
                    slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The tag leaving the pipe this cycle is written now, so only younger tags block.
                if (tag_vld_q[MAC_LAT-2:0] == '0) begin
                    state_d = S_RED_ISSUE;
                end
            end
            S_RED_ISSUE: begin
                mac_a   = psum_q[red_q];
                mac_b   = ONE;
                mac_c   = (red_q == SLOT_W'(1)) ? psum_q[0] : acc_q;
                wait_d  = '0;
                state_d = S_RED_WAIT;
            end
            S_RED_WAIT: begin
                if (wait_q == LAST_SLOT) begin
                    acc_d = mac_z;
                    if (red_q == LAST_SLOT) begin
                        state_d = S_DONE;
                    end else begin
                        red_d   = red_q + 1'b1;
                        state_d = S_RED_ISSUE;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tag_vld_d     = {tag_vld_q[MAC_LAT-2:0], issue};
        tag_slot_d[0] = slot_q;
        for (int i = 1; i < MAC_LAT; i++) begin
            tag_slot_d[i] = tag_slot_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            slot_q     <= '0;
            red_q      <= '0;
            wait_q     <= '0;
            acc_q      <= '0;
            psum_q     <= '0;
            tag_vld_q  <= '0;
            tag_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            slot_q     <= slot_d;
            red_q      <= red_d;
            wait_q     <= wait_d;
            acc_q      <= acc_d;
            psum_q     <= psum_d;
            tag_vld_q  <= tag_vld_d;
            tag_slot_q <= tag_slot_d;
        end
    end

`ifdef MAC_DOT_SCHED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && cmd_valid) begin
            stall_d = '0;
        end else if ((state_q == S_ACCUM) && in_ready && !in_valid && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_dot_sched.sv
// tb_mac_dot_sched: randomized scoreboard bench for mac_dot_sched with an fp32 MAC model.
// Expected dot products come from plain real-valued sums of exactly representable operands.
module tb_mac_dot_sched;

    localparam int DATA_W  = 32;
    localparam int MAC_LAT = 4;
    localparam int LEN_W   = 16;
    localparam int RED_LAT = MAC_LAT * (MAC_LAT + 1);
    localparam int MAX_OPS = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [DATA_W-1:0] mac_c;
    logic [DATA_W-1:0] mac_z;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;
`ifdef MAC_DOT_SCHED_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    mac_dot_sched #(
        .DATA_W (DATA_W),
        .MAC_LAT(MAC_LAT),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len  (cmd_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_c    (mac_c),
        .mac_z    (mac_z),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .busy     (busy)
`ifdef MAC_DOT_SCHED_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    function automatic real f2r(input logic [31:0] x);
        int  e;
        real v;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(x[22:0]) / 8388608.0;
        for (int i = 127; i < e; i++) v = v * 2.0;
        for (int i = e; i < 127; i++) v = v / 2.0;
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic s;
        int   e;
        real  m;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 127;
        while (m >= 2.0 && e < 254) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    // Behavioural fp32 MAC with MAC_LAT cycles from inputs to z; never reset, so stale results keep flowing.
    logic [MAC_LAT-1:0][DATA_W-1:0] mac_pipe = '0;
    always @(posedge clk) begin
        mac_pipe <= {mac_pipe[MAC_LAT-2:0], r2f(f2r(mac_a) * f2r(mac_b) + f2r(mac_c))};
    end
    assign mac_z = mac_pipe[MAC_LAT-1];

    typedef struct {
        logic [31:0] data;
        int          len;
        int          bubbles;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] op_a [MAX_OPS];
    logic [31:0] op_b [MAX_OPS];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: got no handshake, expected one within the cycle budget (cycle %0d)", name, cyc);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_res_data"}, res_data, 32'd0);
        checkOutput({tag, "_mac_a"}, mac_a, 32'd0);
        checkOutput({tag, "_mac_b"}, mac_b, 32'd0);
        checkOutput({tag, "_mac_c"}, mac_c, 32'd0);
`ifdef MAC_DOT_SCHED_STALL_CNT_EN
        checkOutput({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard when a result appears and checks it every cycle it is presented.
    bit res_seen = 1'b0;
    bit has_cur  = 1'b0;
    bit post_hs  = 1'b0;
    int last_in_cyc = 0;
    int cmd_cyc = 0;
    int hs_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            res_seen = 1'b0;
            has_cur  = 1'b0;
            post_hs  = 1'b0;
        end else begin
            if (post_hs) begin
                checkOutput("cmd_ready_after_res", 32'(cmd_ready), 32'd1);
                checkOutput("busy_after_res", 32'(busy), 32'd0);
                post_hs = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                cmd_cyc = cyc;
                hs_cnt  = 0;
            end
            if (in_valid && in_ready) begin
                last_in_cyc = cyc;
                hs_cnt++;
            end
            if (res_valid) begin
                if (!res_seen) begin
                    res_seen = 1'b1;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_result: got %h, expected no result (cycle %0d)", res_data, cyc);
                    end else begin
                        cur     = sb.pop_front();
                        has_cur = 1'b1;
                        checkOutput("operand_count", 32'(hs_cnt), 32'(cur.len));
                        if (cur.len == 0) checkOutput("latency_len0", 32'(cyc - cmd_cyc), 32'd1);
                        else checkOutput("latency", 32'(cyc - last_in_cyc), 32'(RED_LAT));
`ifdef MAC_DOT_SCHED_STALL_CNT_EN
                        checkOutput("stall_cnt", stall_cnt, 32'(cur.bubbles));
`endif
                    end
                end
                if (has_cur) begin
                    checkOutput("res_data", res_data, cur.data);
                    checkOutput("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
                end
                if (res_ready) begin
                    res_seen = 1'b0;
                    has_cur  = 1'b0;
                    post_hs  = 1'b1;
                end
            end
        end
    end

    // One command from op_a/op_b. mode: 0 gap-free, 1 bubble before every odd operand, 2 random bubbles.
    task automatic applyStimulus(input int len, input int mode, input int delay);
        exp_t e;
        real  sum;
        int   bubbles;
        bit   bub [MAX_OPS];
        int   w;
        int   cnt;
        bit   done;
        sum     = 0.0;
        bubbles = 0;
        for (int i = 0; i < len; i++) begin
            case (mode)
                1:       bub[i] = (i % 2 == 1);
                2:       bub[i] = ($urandom_range(0, 3) == 0);
                default: bub[i] = 1'b0;
            endcase
            if (bub[i]) bubbles++;
            sum += f2r(op_a[i]) * f2r(op_b[i]);
        end
        e.data    = r2f(sum);
        e.len     = len;
        e.bubbles = bubbles;
        sb.push_back(e);

        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        if (!cmd_ready) reportTimeout("cmd_accept");
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        for (int i = 0; i < len; i++) begin
            if (bub[i]) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_a     = op_a[i];
            in_b     = op_b[i];
            @(negedge clk);
            checkOutput("in_ready_accum", 32'(in_ready), 32'd1);
            w = 0;
            while (!in_ready && w < 100) begin @(negedge clk); w++; end
            if (!in_ready) reportTimeout("operand_accept");
            @(posedge clk); #1;
        end

        // Keep offering junk so any extra operand acceptance shows up in the operand count.
        in_valid  = 1'b1;
        in_a      = $urandom();
        in_b      = $urandom();
        res_ready = 1'b0;
        cnt  = 0;
        w    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (res_valid && res_ready) done = 1'b1;
            else if (w >= 2000) begin reportTimeout("result"); done = 1'b1; end
            else begin
                w++;
                if (res_valid) cnt++;
            end
            @(posedge clk); #1;
            if (!done) res_ready = (cnt > delay);
        end
        res_ready = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
    endtask

    task automatic resetMidAccum();
        int w;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(8);
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        if (!cmd_ready) reportTimeout("cmd_accept_rst");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h40000000;
            in_b     = 32'h40400000;
            @(posedge clk); #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic randomOps(input int len);
        for (int i = 0; i < len; i++) begin
            op_a[i] = r2f(real'($urandom_range(0, 16)) - 8.0);
            op_b[i] = r2f((real'($urandom_range(0, 8)) - 4.0) * 0.5);
        end
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            op_a[i] = r2f(real'(i + 1));
            op_b[i] = 32'h3F800000;
        end
        applyStimulus(8, 0, 0);

        op_a[0] = 32'h40000000; op_a[1] = 32'h40400000; op_a[2] = 32'h40800000;
        for (int i = 0; i < 3; i++) op_b[i] = 32'h3F000000;
        applyStimulus(3, 0, 1);

        randomOps(9);
        applyStimulus(9, 1, 2);

        applyStimulus(0, 0, 5);

        resetMidAccum();
        op_a[0] = 32'h3F800000; op_a[1] = 32'h3F800000;
        op_b[0] = 32'h3F800000; op_b[1] = 32'h3F800000;
        applyStimulus(2, 0, 0);

        randomOps(8);
        applyStimulus(8, 1, 0);

        for (int k = 0; k < 14; k++) begin
            int len;
            len = $urandom_range(0, 20);
            randomOps(len);
            applyStimulus(len, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got a run still going, expected it to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
